// File: rtl/edac_pkg.sv
// Shared EDAC definitions for the 4-bit encoder/decoder pair.
// Hamming(7,4) bit layout, error code and FSM states.
package edac_pkg;

  localparam int D0_POS = 2;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;
  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 3;

  localparam logic [15:0] ERROR_WORD = 16'hFFFF;
  localparam logic [2:0]  FIX_MAX    = 3'h4;

  typedef enum logic [1:0] {
    IDLE,
    CRC,
    OUT
  } state_e;

  function automatic logic [7:0] hamming74_enc(input logic [3:0] d);
    logic [7:0] b;
    b         = 8'h00;
    b[D0_POS] = d[0];
    b[D1_POS] = d[1];
    b[D2_POS] = d[2];
    b[D3_POS] = d[3];
    b[P0_POS] = b[D0_POS] ^ b[D1_POS] ^ b[D3_POS];
    b[P1_POS] = b[D0_POS] ^ b[D2_POS] ^ b[D3_POS];
    b[P2_POS] = b[D1_POS] ^ b[D2_POS] ^ b[D3_POS];
    return b;
  endfunction

endpackage

// File: rtl/crc8_serial_div.sv
// Bit-serial CRC divider: one long-division step per step_i.
// rem_o is the low byte after the step taken this cycle.
module crc8_serial_div (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [7:0] byte_i,
  input  logic [7:0] poly_i,
  output logic       last_o,
  output logic [7:0] rem_o
);

  logic [15:0] work_q, work_d;
  logic [15:0] psh_q, psh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  idx;
  logic [15:0] work_step;

  // One division step, then load/step/hold selection.
  always_comb begin
    idx       = 4'd15 - {1'b0, cnt_q};
    work_step = work_q[idx] ? (work_q ^ psh_q) : work_q;
    work_d    = work_q;
    psh_d     = psh_q;
    cnt_d     = cnt_q;
    if (load_i) begin
      work_d = {byte_i, 8'h00};
      psh_d  = {poly_i, 8'h00};
      cnt_d  = 3'd0;
    end else if (step_i) begin
      work_d = work_step;
      psh_d  = psh_q >> 1;
      cnt_d  = cnt_q + 3'd1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      psh_q  <= '0;
      cnt_q  <= '0;
    end else begin
      work_q <= work_d;
      psh_q  <= psh_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last_o = (cnt_q == 3'd7);
  assign rem_o  = work_step[7:0];

endmodule

// File: rtl/edac_encode_4bit.sv
// EDAC write-side encoder: nibble -> {Hamming(7,4) byte, CRC byte}.
// Handshaked in and out; CRC runs one bit per enabled cycle.
module edac_encode_4bit
  import edac_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        din,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [7:0]        crc_poly,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       dout,
  output logic [ADDR_W-1:0] addr_out
);

  state_e            state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic [15:0]       dout_q, dout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              accept;
  logic              step;
  logic              last;
  logic [7:0]        rem;

  assign in_ready = rst_n && en && (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign step     = en && (state_q == CRC);

  crc8_serial_div u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .step_i (step),
    .byte_i (hamming74_enc(din)),
    .poly_i (crc_poly),
    .last_o (last),
    .rem_o  (rem)
  );

  // Next-state and datapath capture for IDLE -> CRC -> OUT.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          byte_d  = hamming74_enc(din);
          addr_d  = addr_in;
          state_d = CRC;
        end
      end
      CRC: begin
        if (step && last) begin
          dout_d  = {byte_q, rem};
          state_d = OUT;
        end
      end
      OUT: begin
        if (en && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= '0;
      dout_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
    end
  end

  assign out_valid = (state_q == OUT);
  assign dout      = dout_q;
  assign addr_out  = addr_q;

endmodule

// File: tb/tb_edac_encode_4bit.sv
// Directed bench for edac_encode_4bit.
// Includes a small decoder model as scoreboard.
module tb_edac_encode_4bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  din = 4'h0;
  logic [7:0]  addr_in = 8'h00;
  logic [7:0]  crc_poly = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] dout;
  logic [7:0]  addr_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edac_encode_4bit #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .addr_in   (addr_in),
    .crc_poly  (crc_poly),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .addr_out  (addr_out)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Remainder of {b,8'h00} modulo the 9-bit divisor {poly,0}.
  function automatic logic [7:0] crc_ref(input logic [7:0] b,
                                         input logic [7:0] p);
    logic [15:0] r;
    logic [15:0] dv;
    r  = {b, 8'h00};
    dv = {7'h00, p, 1'b0};
    for (int k = 15; k >= 8; k--)
      if (r[k]) r = r ^ (dv << (k - 8));
    return r[7:0];
  endfunction

  function automatic logic [2:0] syn(input logic [7:0] b);
    syn[0] = b[0] ^ b[2] ^ b[4] ^ b[6];
    syn[1] = b[1] ^ b[2] ^ b[5] ^ b[6];
    syn[2] = b[3] ^ b[4] ^ b[5] ^ b[6];
  endfunction

  task automatic accept(input logic [3:0] d,
                        input logic [7:0] p,
                        input logic [7:0] a);
    int n;
    n = 0;
    din = d;
    crc_poly = p;
    addr_in = a;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("acc_wait", 32'(n < 20), 32'd1);
    tick();
    in_valid = 1'b0;
    crc_poly = 8'h5A;
    din = ~d;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_ov", 32'(out_valid), 32'd0);
  endtask

  task automatic run(input string tag, input logic [3:0] d,
                     input logic [7:0] p, input logic [7:0] a,
                     input logic [15:0] exp);
    int n;
    accept(d, p, a);
    wait_out(n);
    check({tag, "_lat"}, 32'(n), 32'd8);
    check({tag, "_dout"}, 32'(dout), 32'(exp));
    check({tag, "_addr"}, 32'(addr_out), 32'(a));
    pop();
  endtask

  initial begin
    int n;
    logic seen;
    logic [7:0] p;
    logic [7:0] b;
    #2;
    check("rst_ir", 32'(in_ready), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_addr", 32'(addr_out), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rel_ir", 32'(in_ready), 32'd1);

    run("v0", 4'h0, 8'hC0, 8'h12, 16'h0000);
    run("vF", 4'hF, 8'hC0, 8'h21, 16'h7F80);
    run("v1", 4'h1, 8'hC0, 8'h31, 16'h0780);
    run("vF80", 4'hF, 8'h80, 8'h41, 16'h7F00);

    // Backpressure with a pending request.
    accept(4'hF, 8'hC0, 8'h33);
    wait_out(n);
    check("bp_lat", 32'(n), 32'd8);
    din = 4'h1;
    crc_poly = 8'hC0;
    addr_in = 8'h44;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_dout", 32'(dout), 32'h7F80);
      check("bp_ir", 32'(in_ready), 32'd0);
      check("bp_ov", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_hs_ov", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    wait_out(n);
    check("bp2_lat", 32'(n), 32'd8);
    check("bp2_dout", 32'(dout), 32'h0780);
    check("bp2_addr", 32'(addr_out), 32'h44);
    pop();

    // Enable low for 3 cycles after CRC step 4.
    accept(4'hF, 8'hC0, 8'h66);
    repeat (4) tick();
    en = 1'b0;
    repeat (3) tick();
    check("en_ov", 32'(out_valid), 32'd0);
    en = 1'b1;
    wait_out(n);
    check("en_lat", 32'(n + 7), 32'd11);
    check("en_dout", 32'(dout), 32'h7F80);
    en = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("en_out_hold", 32'(out_valid), 32'd1);
    check("en_out_dout", 32'(dout), 32'h7F80);
    en = 1'b1;
    tick();
    out_ready = 1'b0;
    check("en_out_rel", 32'(out_valid), 32'd0);

    // Reset pulse in the middle of CRC.
    accept(4'hF, 8'hC0, 8'h55);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'h0);
    check("mid_rst_addr", 32'(addr_out), 32'h0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("mid_rst_noout", 32'(seen), 32'd0);
    run("post_rst", 4'h1, 8'hC0, 8'h77, 16'h0780);

    // Scoreboard: every nibble with a random divisor.
    for (int i = 0; i < 16; i++) begin
      p = 8'($urandom_range(0, 255));
      accept(4'(i), p, 8'(i + 8'h80));
      wait_out(n);
      check("sb_lat", 32'(n), 32'd8);
      b = dout[15:8];
      check("sb_valid",
            32'((syn(b) == 3'd0) && (crc_ref(b, p) == dout[7:0])
                && (dout != 16'hFFFF) && !dout[15] && !dout[0]),
            32'd1);
      check("sb_data", 32'({b[6], b[5], b[4], b[2]}), 32'(i));
      check("sb_addr", 32'(addr_out), 32'(i + 8'h80));
      pop();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
